regfile_issue_wb: RTL and testbench

// - Parametrised multi-register file with instruction issue and ALU write-back tracking.
// - Decodes {rd, rs2, rs1} and issues registered op1/op2 to a fixed-latency ALU.
// - Writes alu_result back to rd ALU_LAT cycles later.
// - Stalls on RAW hazards; forwards the write-back value when it lands in the read cycle.

---
 rtl/regfile_pkg.sv | 37 +++
 rtl/regfile_wb_pipe.sv | 59 +++++
 rtl/regfile_issue_wb.sv | 112 +++++++++++
 tb/tb_regfile_issue_wb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the issue/write-back register file.
package regfile_pkg;

  // Widest register address the pending pipe can track (up to 32 registers).
  localparam int MAX_AW = 5;

  // Widest ALU result the resize helper handles.
  localparam int MAX_WIDTH = 64;

  // Instruction field positions, in units of AW bits: {rd, rs2, rs1}.
  localparam int RS1_FIELD    = 0;
  localparam int RS2_FIELD    = 1;
  localparam int RD_FIELD     = 2;
  localparam int INSTR_FIELDS = 3;

  // One slot of the pending write-back pipe: valid flag plus destination.
  typedef struct packed {
    logic              v;
    logic [MAX_AW-1:0] rd;
  } pend_t;

  // Zero-extend an ALU result of the given width into the wide container;
  // the caller truncates to the register width.
  function automatic logic [MAX_WIDTH-1:0] resize_result(
    input logic [MAX_WIDTH-1:0] value,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    if (width >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/regfile_wb_pipe.sv
// Pending write-back pipe: tracks destinations of issued ops until their
// ALU result lands, and reports hazards and forwarding matches.
module regfile_wb_pipe
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ALU_LAT  = 2,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_issue,
  input  logic [AW-1:0] i_rd,
  input  logic          i_flush,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  output logic          o_wb_valid,
  output logic [AW-1:0] o_wb_addr,
  output logic          o_hazard,
  output logic          o_fwd1,
  output logic          o_fwd2
);

  pend_t r_pend [1:ALU_LAT];
  logic  w_hazard;

  // A pending entry matches a source unless it is the hardwired zero register.
  function automatic logic hits(input pend_t e, input logic [AW-1:0] rs);
    return e.v && (e.rd == MAX_AW'(rs)) && !(ZERO_REG && (rs == '0));
  endfunction

  // Shift the pipe every cycle; a stalled cycle injects an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= ALU_LAT; k++) r_pend[k] <= '0;
    end else if (i_flush) begin
      for (int k = 1; k <= ALU_LAT; k++) r_pend[k] <= '0;
    end else begin
      r_pend[1] <= i_issue ? pend_t'({1'b1, MAX_AW'(i_rd)}) : '0;
      for (int k = 2; k <= ALU_LAT; k++) r_pend[k] <= r_pend[k-1];
    end
  end

  // Any source matching a slot that has not yet reached write-back stalls.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 1; k < ALU_LAT; k++) begin
      if (hits(r_pend[k], i_rs1) || hits(r_pend[k], i_rs2)) w_hazard = 1'b1;
    end
  end

  assign o_hazard   = w_hazard;
  assign o_fwd1     = hits(r_pend[ALU_LAT], i_rs1);
  assign o_fwd2     = hits(r_pend[ALU_LAT], i_rs2);
  assign o_wb_valid = r_pend[ALU_LAT].v && !i_flush;
  assign o_wb_addr  = r_pend[ALU_LAT].rd[AW-1:0];

endmodule

// File: rtl/regfile_issue_wb.sv
// Register file that issues operand pairs to a fixed-latency ALU and writes
// the ALU result back to the destination register ALU_LAT cycles later.
module regfile_issue_wb
  import regfile_pkg::*;
#(
  parameter int REGF_WIDTH = 16,
  parameter int ALU_WIDTH  = 16,
  parameter int NUM_REGS   = 4,
  parameter int ALU_LAT    = 2,
  parameter bit ZERO_REG   = 1'b0,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_instr_valid,
  output logic                         o_instr_ready,
  input  logic [INSTR_FIELDS*AW-1:0]   i_instruction,
  input  logic                         i_flush,
  output logic [REGF_WIDTH-1:0]        o_op1,
  output logic [REGF_WIDTH-1:0]        o_op2,
  output logic                         o_op_valid,
  input  logic [ALU_WIDTH-1:0]         i_alu_result,
  output logic                         o_wb_valid,
  output logic [AW-1:0]                o_wb_addr
);

  logic [REGF_WIDTH-1:0] r_regs [NUM_REGS];
  logic [REGF_WIDTH-1:0] r_op1;
  logic [REGF_WIDTH-1:0] r_op2;
  logic                  r_op_valid;

  logic [AW-1:0]         w_rs1;
  logic [AW-1:0]         w_rs2;
  logic [AW-1:0]         w_rd;
  logic                  w_hazard;
  logic                  w_fwd1;
  logic                  w_fwd2;
  logic                  w_ready;
  logic                  w_issue;
  logic                  w_wb_valid;
  logic [AW-1:0]         w_wb_addr;
  logic [REGF_WIDTH-1:0] w_wb_data;
  logic [REGF_WIDTH-1:0] w_read1;
  logic [REGF_WIDTH-1:0] w_read2;

  assign w_rs1 = i_instruction[RS1_FIELD*AW +: AW];
  assign w_rs2 = i_instruction[RS2_FIELD*AW +: AW];
  assign w_rd  = i_instruction[RD_FIELD*AW  +: AW];

  assign w_wb_data = REGF_WIDTH'(resize_result(MAX_WIDTH'(i_alu_result), ALU_WIDTH));

  // Ready depends only on hazard and flush, so instr_valid never loops back.
  assign w_ready = !w_hazard && !i_flush;
  assign w_issue = i_instr_valid && w_ready;

  regfile_wb_pipe #(
    .NUM_REGS (NUM_REGS),
    .ALU_LAT  (ALU_LAT),
    .ZERO_REG (ZERO_REG)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (w_issue),
    .i_rd       (w_rd),
    .i_flush    (i_flush),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_wb_valid (w_wb_valid),
    .o_wb_addr  (w_wb_addr),
    .o_hazard   (w_hazard),
    .o_fwd1     (w_fwd1),
    .o_fwd2     (w_fwd2)
  );

  // Operand read: the landing write-back value bypasses the array.
  always_comb begin
    w_read1 = w_fwd1 ? w_wb_data : r_regs[w_rs1];
    w_read2 = w_fwd2 ? w_wb_data : r_regs[w_rs2];
  end

  // Write decoder; the zero register (when enabled) silently drops writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_valid && !(ZERO_REG && (w_wb_addr == '0))) begin
      r_regs[w_wb_addr] <= w_wb_data;
    end
  end

  // Operand registers hold their value across stalls; op_valid pulses per issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= w_issue;
      if (w_issue) begin
        r_op1 <= w_read1;
        r_op2 <= w_read2;
      end
    end
  end

  assign o_instr_ready = w_ready;
  assign o_op1         = r_op1;
  assign o_op2         = r_op2;
  assign o_op_valid    = r_op_valid;
  assign o_wb_valid    = w_wb_valid;
  assign o_wb_addr     = w_wb_addr;

endmodule

// File: tb/tb_regfile_issue_wb.sv
// Self-checking bench: directed vector table, mid-op reset, randomized run
// against an in-flight list model, plus zero-register and ALU_LAT=1 variants.
module tb_regfile_issue_wb;

  logic clk = 1'b0;
  logic rst_n;

  // Main DUT: defaults (NUM_REGS=4, ALU_LAT=2, ZERO_REG=0)
  logic        mValid, mFlush, mReady, mOpV, mWbV;
  logic [5:0]  mInstr;
  logic [15:0] mAlu, mOp1, mOp2;
  logic [1:0]  mWbA;

  // Zero-register DUT
  logic        zValid, zFlush, zReady, zOpV, zWbV;
  logic [5:0]  zInstr;
  logic [15:0] zAlu, zOp1, zOp2;
  logic [1:0]  zWbA;

  // ALU_LAT=1, NUM_REGS=8 DUT
  logic        lValid, lFlush, lReady, lOpV, lWbV;
  logic [8:0]  lInstr;
  logic [15:0] lAlu, lOp1, lOp2;
  logic [2:0]  lWbA;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  regfile_issue_wb dut (
    .clk(clk), .rst_n(rst_n), .i_instr_valid(mValid), .o_instr_ready(mReady),
    .i_instruction(mInstr), .i_flush(mFlush), .o_op1(mOp1), .o_op2(mOp2),
    .o_op_valid(mOpV), .i_alu_result(mAlu), .o_wb_valid(mWbV), .o_wb_addr(mWbA)
  );

  regfile_issue_wb #(.ZERO_REG(1'b1)) dutZ (
    .clk(clk), .rst_n(rst_n), .i_instr_valid(zValid), .o_instr_ready(zReady),
    .i_instruction(zInstr), .i_flush(zFlush), .o_op1(zOp1), .o_op2(zOp2),
    .o_op_valid(zOpV), .i_alu_result(zAlu), .o_wb_valid(zWbV), .o_wb_addr(zWbA)
  );

  regfile_issue_wb #(.NUM_REGS(8), .ALU_LAT(1)) dutL (
    .clk(clk), .rst_n(rst_n), .i_instr_valid(lValid), .o_instr_ready(lReady),
    .i_instruction(lInstr), .i_flush(lFlush), .o_op1(lOp1), .o_op2(lOp2),
    .o_op_valid(lOpV), .i_alu_result(lAlu), .o_wb_valid(lWbV), .o_wb_addr(lWbA)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  instr;
    logic        flush;
    logic [15:0] alu;
    logic        expReady;
    logic        expWbV;
    logic [1:0]  expWbA;
    logic        expOpV;
    logic [15:0] expOp1;
    logic [15:0] expOp2;
  } vec_t;

  typedef struct {
    int rd;
    int wbCyc;
  } flight_t;

  vec_t        vecs [11];
  flight_t     inflight [$];
  logic [15:0] modelRegs [4];
  logic [15:0] heldOp1, heldOp2, val1, val2;
  logic        hazard, expReady, expWbV, accept;
  logic [1:0]  expWbA;
  int          rs1, rs2, rd, wbIdx, cyc;

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle on the main DUT, checking comb outputs then registered ones.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    mValid = v.valid; mInstr = v.instr; mFlush = v.flush; mAlu = v.alu;
    #1;
    checkOutput({tag, ".ready"}, 32'(mReady), 32'(v.expReady));
    checkOutput({tag, ".wb_valid"}, 32'(mWbV), 32'(v.expWbV));
    checkOutput({tag, ".wb_addr"}, 32'(mWbA), 32'(v.expWbA));
    @(posedge clk);
    #1;
    checkOutput({tag, ".op_valid"}, 32'(mOpV), 32'(v.expOpV));
    checkOutput({tag, ".op1"}, 32'(mOp1), 32'(v.expOp1));
    checkOutput({tag, ".op2"}, 32'(mOp2), 32'(v.expOp2));
  endtask

  // One cycle on the zero-register DUT.
  task automatic applyStimulusZ(input logic valid, input logic [5:0] instr,
                                input logic [15:0] alu, input logic expRdy,
                                input logic [15:0] exp1, input logic [15:0] exp2,
                                input string tag);
    @(negedge clk);
    zValid = valid; zInstr = instr; zAlu = alu;
    #1;
    checkOutput({tag, ".ready"}, 32'(zReady), 32'(expRdy));
    @(posedge clk);
    #1;
    checkOutput({tag, ".op_valid"}, 32'(zOpV), 32'(valid && expRdy));
    checkOutput({tag, ".op1"}, 32'(zOp1), 32'(exp1));
    checkOutput({tag, ".op2"}, 32'(zOp2), 32'(exp2));
  endtask

  // One cycle on the single-cycle-latency DUT.
  task automatic applyStimulusL(input logic valid, input logic [8:0] instr,
                                input logic [15:0] alu, input logic expRdy,
                                input logic [15:0] exp1, input logic [15:0] exp2,
                                input string tag);
    @(negedge clk);
    lValid = valid; lInstr = instr; lAlu = alu;
    #1;
    checkOutput({tag, ".ready"}, 32'(lReady), 32'(expRdy));
    @(posedge clk);
    #1;
    checkOutput({tag, ".op_valid"}, 32'(lOpV), 32'(valid && expRdy));
    checkOutput({tag, ".op1"}, 32'(lOp1), 32'(exp1));
    checkOutput({tag, ".op2"}, 32'(lOp2), 32'(exp2));
  endtask

  // Test sequence: reset, vector table, mid-op reset, random run, variants.
  initial begin
    rst_n = 1'b0;
    mValid = 0; mInstr = '0; mFlush = 0; mAlu = '0;
    zValid = 0; zInstr = '0; zFlush = 0; zAlu = '0;
    lValid = 0; lInstr = '0; lFlush = 0; lAlu = '0;

    // {valid, instr{rd,rs2,rs1}, flush, alu, ready, wbV, wbA, opV, op1, op2}
    vecs[0]  = '{1'b1, 6'h1B, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 6'h20, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 6'h3E, 1'b0, 16'h00A5, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 6'h3E, 1'b0, 16'h1234, 1'b1, 1'b1, 2'd2, 1'b1, 16'h1234, 16'h0000};
    vecs[4]  = '{1'b1, 6'h11, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h00A5, 16'h0000};
    vecs[5]  = '{1'b1, 6'h09, 1'b0, 16'h0077, 1'b0, 1'b1, 2'd3, 1'b0, 16'h00A5, 16'h0000};
    vecs[6]  = '{1'b1, 6'h09, 1'b0, 16'h1234, 1'b1, 1'b1, 2'd1, 1'b1, 16'h1234, 16'h1234};
    vecs[7]  = '{1'b1, 6'h3F, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0077, 16'h0077};
    vecs[8]  = '{1'b0, 6'h00, 1'b0, 16'h5555, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0077, 16'h0077};
    vecs[9]  = '{1'b0, 6'h00, 1'b1, 16'hDEAD, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0077, 16'h0077};
    vecs[10] = '{1'b1, 6'h2C, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h5555, 16'h0077};

    repeat (2) @(negedge clk);
    checkOutput("reset.op_valid", 32'(mOpV), 32'd0);
    checkOutput("reset.op1", 32'(mOp1), 32'd0);
    checkOutput("reset.op2", 32'(mOp2), 32'd0);
    checkOutput("reset.wb_valid", 32'(mWbV), 32'd0);
    checkOutput("reset.wb_addr", 32'(mWbA), 32'd0);
    checkOutput("reset.ready", 32'(mReady), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-cycle while op_valid=1 and a write is in flight.
    @(negedge clk);
    mValid = 1'b0; mInstr = '0; mAlu = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst.op_valid", 32'(mOpV), 32'd0);
    checkOutput("midrst.op1", 32'(mOp1), 32'd0);
    checkOutput("midrst.op2", 32'(mOp2), 32'd0);
    checkOutput("midrst.wb_valid", 32'(mWbV), 32'd0);
    checkOutput("midrst.wb_addr", 32'(mWbA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mAlu = '0;
    applyStimulus('{1'b1, 6'h16, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0000}, "rdback0");
    applyStimulus('{1'b1, 6'h0C, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h0000, 16'h0000}, "rdback1");

    // Randomized run against the in-flight list model.
    @(negedge clk);
    mValid = 1'b0; mFlush = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) modelRegs[i] = '0;
    inflight.delete();
    heldOp1 = '0; heldOp2 = '0;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      mValid = ($urandom_range(3) != 0);
      mInstr = 6'($urandom);
      mFlush = ($urandom_range(15) == 0);
      mAlu   = 16'($urandom);
      rs1 = int'(mInstr[1:0]);
      rs2 = int'(mInstr[3:2]);
      rd  = int'(mInstr[5:4]);
      hazard = 1'b0;
      wbIdx  = -1;
      foreach (inflight[j]) begin
        if (inflight[j].wbCyc == cyc) wbIdx = j;
        else if (inflight[j].rd == rs1 || inflight[j].rd == rs2) hazard = 1'b1;
      end
      expReady = !hazard && !mFlush;
      expWbV   = (wbIdx >= 0) && !mFlush;
      expWbA   = (wbIdx >= 0) ? 2'(inflight[wbIdx].rd) : 2'd0;
      accept   = mValid && expReady;
      val1 = (wbIdx >= 0 && inflight[wbIdx].rd == rs1) ? mAlu : modelRegs[rs1];
      val2 = (wbIdx >= 0 && inflight[wbIdx].rd == rs2) ? mAlu : modelRegs[rs2];
      if (accept) begin
        heldOp1 = val1;
        heldOp2 = val2;
      end
      #1;
      checkOutput("rand.ready", 32'(mReady), 32'(expReady));
      checkOutput("rand.wb_valid", 32'(mWbV), 32'(expWbV));
      checkOutput("rand.wb_addr", 32'(mWbA), 32'(expWbA));
      @(posedge clk);
      #1;
      checkOutput("rand.op_valid", 32'(mOpV), 32'(accept));
      checkOutput("rand.op1", 32'(mOp1), 32'(heldOp1));
      checkOutput("rand.op2", 32'(mOp2), 32'(heldOp2));
      if (expWbV) modelRegs[expWbA] = mAlu;
      if (mFlush) begin
        inflight.delete();
      end else begin
        if (wbIdx >= 0) inflight.delete(wbIdx);
        if (accept) inflight.push_back('{rd, cyc + 2});
      end
      cyc++;
    end
    @(negedge clk);
    mValid = 1'b0; mFlush = 1'b0;

    // Zero register: writes to x0 vanish and x0 never stalls or forwards.
    applyStimulusZ(1'b1, 6'h00, 16'h0000, 1'b1, 16'h0000, 16'h0000, "zero0");
    applyStimulusZ(1'b1, 6'h10, 16'h0000, 1'b1, 16'h0000, 16'h0000, "zero1");
    applyStimulusZ(1'b1, 6'h20, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, "zero2");
    applyStimulusZ(1'b1, 6'h30, 16'hABCD, 1'b1, 16'h0000, 16'h0000, "zero3");
    applyStimulusZ(1'b0, 6'h00, 16'h0000, 1'b1, 16'h0000, 16'h0000, "zero4");
    applyStimulusZ(1'b1, 6'h04, 16'h0000, 1'b1, 16'h0000, 16'hABCD, "zero5");
    @(negedge clk);
    zValid = 1'b0;

    // Single-cycle ALU: dependent chain issues every cycle via forwarding.
    applyStimulusL(1'b1, 9'h140, 16'h0000, 1'b1, 16'h0000, 16'h0000, "lat1_0");
    applyStimulusL(1'b1, 9'h145, 16'h1111, 1'b1, 16'h1111, 16'h0000, "lat1_1");
    applyStimulusL(1'b1, 9'h1A8, 16'h2222, 1'b1, 16'h0000, 16'h2222, "lat1_2");
    applyStimulusL(1'b1, 9'h02E, 16'h3333, 1'b1, 16'h3333, 16'h2222, "lat1_3");
    @(negedge clk);
    lValid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
